// File: rtl/true_dpbram_be.sv
// True dual-port RAM with per-column write enables, selectable read-during-write mode and a 1/2-stage read pipeline.
// Read result after RD_LATENCY cycles with a one-cycle valid strobe; no backpressure, both ports accept a request every cycle.
module true_dpbram_be #(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 12,
   parameter int MEM_SIZE   = 3840,
   parameter int NB_COL     = 2,
   parameter int RD_LATENCY = 1,
   parameter int WR_MODE    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] addr0_i,
   input  logic              ce0_i,
   input  logic [NB_COL-1:0] we0_i,
   input  logic [DWIDTH-1:0] d0_i,
   input  logic [AWIDTH-1:0] addr1_i,
   input  logic              ce1_i,
   input  logic [NB_COL-1:0] we1_i,
   input  logic [DWIDTH-1:0] d1_i,
   output logic [DWIDTH-1:0] q0_o,
   output logic              q0_valid_o,
   output logic [DWIDTH-1:0] q1_o,
   output logic              q1_valid_o,
   output logic              collision_o
);

   localparam int COL_W = DWIDTH / NB_COL;

   logic [DWIDTH-1:0] ram [MEM_SIZE];

   logic [1:0][AWIDTH-1:0] addr;
   logic [1:0]             ce;
   logic [1:0][NB_COL-1:0] we;
   logic [1:0][DWIDTH-1:0] din;
   logic [1:0][DWIDTH-1:0] mask;
   logic [1:0]             in_rng;
   logic [1:0]             wr;

   logic [1:0][DWIDTH-1:0] s1_dat;
   logic [1:0]             s1_vld;
   logic                   coll_q;

   assign addr = {addr1_i, addr0_i};
   assign ce   = {ce1_i, ce0_i};
   assign we   = {we1_i, we0_i};
   assign din  = {d1_i, d0_i};

   always_comb begin
      in_rng = '0;
      wr     = '0;
      mask   = '0;
      for (int p = 0; p < 2; p++) begin
         in_rng[p] = 32'(addr[p]) < 32'(MEM_SIZE);
         wr[p]     = ce[p] && (|we[p]) && in_rng[p];
         for (int c = 0; c < NB_COL; c++)
            mask[p][c*COL_W +: COL_W] = {COL_W{we[p][c]}};
      end
   end

   // Port 1 is applied first so that port 0 overrides it on overlapping columns.
   always_ff @(posedge clk) begin
      for (int p = 1; p >= 0; p--)
         for (int c = 0; c < NB_COL; c++)
            if (wr[p] && we[p][c])
               ram[addr[p]][c*COL_W +: COL_W] <= din[p][c*COL_W +: COL_W];
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (reset) begin
            s1_vld[p] <= 1'b0;
            s1_dat[p] <= '0;
         end else begin
            s1_vld[p] <= 1'b0;
            if (ce[p] && !(|we[p])) begin
               s1_vld[p] <= 1'b1;
               s1_dat[p] <= in_rng[p] ? ram[addr[p]] : '0;
            end else if (ce[p] && WR_MODE != 2) begin
               s1_vld[p] <= 1'b1;
               if (!in_rng[p])
                  s1_dat[p] <= '0;
               else if (WR_MODE == 1)
                  s1_dat[p] <= (ram[addr[p]] & ~mask[p]) | (din[p] & mask[p]);
               else
                  s1_dat[p] <= ram[addr[p]];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         coll_q <= 1'b0;
      else
         coll_q <= wr[0] && wr[1] && (addr[0] == addr[1]) && (|(we[0] & we[1]));
   end

   assign collision_o = coll_q;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [1:0][DWIDTH-1:0] s2_dat;
         logic [1:0]             s2_vld;

         // Second stage only loads on a valid result so q holds between reads.
         always_ff @(posedge clk) begin
            for (int p = 0; p < 2; p++) begin
               if (reset) begin
                  s2_vld[p] <= 1'b0;
                  s2_dat[p] <= '0;
               end else begin
                  s2_vld[p] <= s1_vld[p];
                  if (s1_vld[p])
                     s2_dat[p] <= s1_dat[p];
               end
            end
         end

         assign q0_o       = s2_dat[0];
         assign q1_o       = s2_dat[1];
         assign q0_valid_o = s2_vld[0];
         assign q1_valid_o = s2_vld[1];
      end else begin : g_lat1
         assign q0_o       = s1_dat[0];
         assign q1_o       = s1_dat[1];
         assign q0_valid_o = s1_vld[0];
         assign q1_valid_o = s1_vld[1];
      end
   endgenerate

endmodule

// File: tb/tb_true_dpbram_be.sv
// Bench for true_dpbram_be: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE at latency 1; READ_FIRST at latency 2)
// share one stimulus stream and are compared every cycle against a word-level memory model.
module tb_true_dpbram_be;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] addr [2];
   logic        ce   [2];
   logic [1:0]  we   [2];
   logic [15:0] d    [2];

   logic [15:0] dq [4][2];
   logic        dv [4][2];
   logic        dc [4];

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic int mode_of(input int k);
      return (k == 3) ? 0 : k;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   generate
      for (genvar k = 0; k < 4; k++) begin : g_dut
         true_dpbram_be #(
            .DWIDTH(16), .AWIDTH(12), .MEM_SIZE(3840), .NB_COL(2),
            .RD_LATENCY((k == 3) ? 2 : 1), .WR_MODE((k == 3) ? 0 : k)
         ) u_dut (
            .clk(clk), .reset(reset),
            .addr0_i(addr[0]), .ce0_i(ce[0]), .we0_i(we[0]), .d0_i(d[0]),
            .addr1_i(addr[1]), .ce1_i(ce[1]), .we1_i(we[1]), .d1_i(d[1]),
            .q0_o(dq[k][0]), .q0_valid_o(dv[k][0]),
            .q1_o(dq[k][1]), .q1_valid_o(dv[k][1]),
            .collision_o(dc[k])
         );
      end
   endgenerate

   // Reference model: word array plus the expected output of each instance.
   logic [15:0] mem [4096];
   logic [15:0] eq [4][2];
   logic        ev [4][2];
   logic [15:0] pd [4][2];
   logic        pv [4][2];
   logic        ecoll;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin : model
      logic [15:0] old, nw;
      logic        inr, col;
      logic [15:0] rd [4][2];
      logic        rv [4][2];
      for (int p = 0; p < 2; p++) begin
         inr = addr[p] < 12'd3840;
         old = inr ? mem[addr[p]] : 16'h0000;
         nw  = old;
         for (int c = 0; c < 2; c++)
            if (we[p][c]) nw[c*8 +: 8] = d[p][c*8 +: 8];
         for (int k = 0; k < 4; k++) begin
            rv[k][p] = ce[p] && (we[p] == 2'b00 || mode_of(k) != 2);
            rd[k][p] = (we[p] != 2'b00 && mode_of(k) == 1) ? (inr ? nw : 16'h0000) : old;
         end
      end
      col = ce[0] && ce[1] && we[0] != 2'b00 && we[1] != 2'b00 && addr[0] == addr[1]
            && addr[0] < 12'd3840 && (we[0] & we[1]) != 2'b00;
      for (int p = 1; p >= 0; p--)
         if (ce[p] && addr[p] < 12'd3840)
            for (int c = 0; c < 2; c++)
               if (we[p][c]) mem[addr[p]][c*8 +: 8] = d[p][c*8 +: 8];
      for (int k = 0; k < 4; k++)
         for (int p = 0; p < 2; p++) begin
            if (reset) begin
               eq[k][p] = 16'h0000; ev[k][p] = 1'b0;
               pd[k][p] = 16'h0000; pv[k][p] = 1'b0;
            end else if (lat_of(k) == 1) begin
               ev[k][p] = rv[k][p];
               if (rv[k][p]) eq[k][p] = rd[k][p];
            end else begin
               ev[k][p] = pv[k][p];
               if (pv[k][p]) eq[k][p] = pd[k][p];
               pv[k][p] = rv[k][p];
               pd[k][p] = rd[k][p];
            end
         end
      ecoll = reset ? 1'b0 : col;
      if (reset) chk_en = 1'b1;
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en)
         for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++) begin
               check($sformatf("valid%0d_inst%0d", p, k), 16'(dv[k][p]), 16'(ev[k][p]));
               if (!$isunknown(eq[k][p]))
                  check($sformatf("q%0d_inst%0d", p, k), dq[k][p], eq[k][p]);
            end
            check($sformatf("collision_inst%0d", k), 16'(dc[k]), 16'(ecoll));
         end
   end

   task automatic step(input logic c0, input logic [1:0] w0, input logic [11:0] a0, input logic [15:0] x0,
                       input logic c1, input logic [1:0] w1, input logic [11:0] a1, input logic [15:0] x1);
      ce[0] = c0; we[0] = w0; addr[0] = a0; d[0] = x0;
      ce[1] = c1; we[1] = w1; addr[1] = a1; d[1] = x1;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 12'd0, 16'h0, 1'b0, 2'b00, 12'd0, 16'h0);
   endtask

   task automatic rd0(input logic [11:0] a);
      step(1'b1, 2'b00, a, 16'h0, 1'b0, 2'b00, 12'd0, 16'h0);
   endtask

   initial begin
      ce[0] = 1'b0; we[0] = 2'b00; addr[0] = '0; d[0] = '0;
      ce[1] = 1'b0; we[1] = 2'b00; addr[1] = '0; d[1] = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_q0", dq[0][0], 16'h0000);
      check("reset_v1", 16'(dv[3][1]), 16'h0);
      check("reset_coll", 16'(dc[0]), 16'h0);

      // Write via port 0, read back via port 1.
      step(1'b1, 2'b11, 12'd5, 16'hABCD, 1'b0, 2'b00, 12'd0, 16'h0);
      step(1'b0, 2'b00, 12'd0, 16'h0, 1'b1, 2'b00, 12'd5, 16'h0);
      check("p1_read5", dq[0][1], 16'hABCD);
      check("p1_read5_vld", 16'(dv[0][1]), 16'h1);
      idle();
      check("p1_vld_drop", 16'(dv[0][1]), 16'h0);
      check("p1_hold", dq[0][1], 16'hABCD);

      // Column write enable.
      step(1'b1, 2'b11, 12'd7, 16'h1234, 1'b0, 2'b00, 12'd0, 16'h0);
      step(1'b1, 2'b01, 12'd7, 16'hFFEE, 1'b0, 2'b00, 12'd0, 16'h0);
      rd0(12'd7);
      check("byte_en", dq[0][0], 16'h12EE);

      // Read-during-write on port 0, cross-port read on port 1.
      step(1'b1, 2'b11, 12'd3, 16'h0001, 1'b0, 2'b00, 12'd0, 16'h0);
      rd0(12'd7);
      step(1'b1, 2'b11, 12'd3, 16'h0002, 1'b1, 2'b00, 12'd3, 16'h0);
      check("rdw_read_first", dq[0][0], 16'h0001);
      check("rdw_write_first", dq[1][0], 16'h0002);
      check("rdw_no_change", dq[2][0], 16'h12EE);
      check("rdw_no_change_vld", 16'(dv[2][0]), 16'h0);
      check("cross_rf", dq[0][1], 16'h0001);
      check("cross_wf", dq[1][1], 16'h0001);
      check("cross_nc", dq[2][1], 16'h0001);
      idle();
      check("rdw_lat2", dq[3][0], 16'h0001);

      // Write/write collisions.
      step(1'b1, 2'b11, 12'd9, 16'hAAAA, 1'b1, 2'b11, 12'd9, 16'h5555);
      check("coll_full", 16'(dc[0]), 16'h1);
      idle();
      check("coll_pulse", 16'(dc[0]), 16'h0);
      rd0(12'd9);
      check("coll_winner", dq[0][0], 16'hAAAA);
      step(1'b1, 2'b10, 12'd9, 16'hAAAA, 1'b1, 2'b01, 12'd9, 16'h5555);
      check("coll_disjoint", 16'(dc[0]), 16'h0);
      rd0(12'd9);
      check("disjoint_merge", dq[0][0], 16'hAA55);

      // Out-of-range access.
      step(1'b1, 2'b11, 12'd0, 16'h1111, 1'b0, 2'b00, 12'd0, 16'h0);
      step(1'b1, 2'b11, 12'd3840, 16'hDEAD, 1'b0, 2'b00, 12'd0, 16'h0);
      rd0(12'd3840);
      check("oor_q", dq[0][0], 16'h0000);
      check("oor_vld", 16'(dv[0][0]), 16'h1);
      rd0(12'd0);
      check("oor_addr0", dq[0][0], 16'h1111);

      // Latency-2 burst.
      step(1'b0, 2'b00, 12'd0, 16'h0, 1'b1, 2'b11, 12'd1, 16'h0101);
      step(1'b0, 2'b00, 12'd0, 16'h0, 1'b1, 2'b11, 12'd2, 16'h0202);
      rd0(12'd0);
      check("lat2_none", 16'(dv[3][0]), 16'h0);
      rd0(12'd1);
      check("lat2_r0", dq[3][0], 16'h1111);
      rd0(12'd2);
      check("lat2_r1", dq[3][0], 16'h0101);
      rd0(12'd3);
      check("lat2_r2", dq[3][0], 16'h0202);
      idle();
      check("lat2_r3", dq[3][0], 16'h0002);
      check("lat2_r3_vld", 16'(dv[3][0]), 16'h1);
      idle();
      check("lat2_end", 16'(dv[3][0]), 16'h0);

      // Reset with reads in flight; a write in the reset cycle still lands.
      rd0(12'd0);
      rd0(12'd1);
      check("rst_first", dq[3][0], 16'h1111);
      reset = 1'b1;
      step(1'b1, 2'b00, 12'd2, 16'h0, 1'b1, 2'b11, 12'd20, 16'h2020);
      reset = 1'b0;
      check("rst_q_lat2", dq[3][0], 16'h0000);
      check("rst_v_lat2", 16'(dv[3][0]), 16'h0);
      check("rst_q_lat1", dq[0][0], 16'h0000);
      idle();
      check("rst_drop1", 16'(dv[3][0]), 16'h0);
      idle();
      check("rst_drop2", 16'(dv[3][0]), 16'h0);
      step(1'b1, 2'b00, 12'd1, 16'h0, 1'b1, 2'b00, 12'd20, 16'h0);
      idle();
      check("rst_mem_kept", dq[3][0], 16'h0101);
      check("rst_cycle_write", dq[0][1], 16'h2020);
      idle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
